// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, req/gnt/rvalid memory handshake, one-entry skid register.
// Define FETCH_TRACE_EN to print each delivered and each discarded fetch.
module fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h8002_0000,
  parameter logic [0:31] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [0:31] imem_rdata,
  output logic [0:31] insn,
  output logic [0:31] pc,
  output logic        valid_insn,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state;
  logic [0:31] fetch_pc;
  logic [0:31] hold_insn;
  logic [0:31] hold_pc;
  logic        hold_valid;
  logic [0:31] redir_pc_al;
  logic [0:31] next_pc;
  logic        out_free;

  always_comb begin
    redir_pc_al = {redirect_pc[0:29], 2'b00};
    next_pc     = fetch_pc + PC_STEP;
    out_free    = !valid_insn || !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fetch_pc         <= RESET_PC;
      hold_insn        <= '0;
      hold_pc          <= '0;
      hold_valid       <= 1'b0;
      imem_req         <= 1'b0;
      imem_addr        <= '0;
      insn             <= '0;
      pc               <= '0;
      valid_insn       <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= 1'b0;
      if (valid_insn && !stall)
        valid_insn <= 1'b0;

      if (redirect_valid) begin
        fetch_pc         <= redir_pc_al;
        valid_insn       <= 1'b0;
        hold_valid       <= 1'b0;
        fetch_misaligned <= |redirect_pc[30:31];
        case (state)
          IDLE: begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= redir_pc_al;
          end
          REQ: begin
            if (imem_gnt) begin
              state    <= DROP;
              imem_req <= 1'b0;
            end else begin
              imem_addr <= redir_pc_al;
            end
          end
          // A response landing on the redirect edge is the stale one; skip DROP.
          WAIT, DROP: begin
            if (imem_rvalid) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= redir_pc_al;
`ifdef FETCH_TRACE_EN
              $display("FETCH DROP PC: %h", imem_addr);
`endif
            end else begin
              state <= DROP;
            end
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (out_free) begin
              if (hold_valid) begin
                insn       <= hold_insn;
                pc         <= hold_pc;
                valid_insn <= 1'b1;
                hold_valid <= 1'b0;
`ifdef FETCH_TRACE_EN
                $display("FETCH PC: %h Insn: %h", hold_pc, hold_insn);
`endif
              end
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
            end
          end
          REQ: begin
            if (imem_gnt) begin
              state    <= WAIT;
              imem_req <= 1'b0;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              fetch_pc <= next_pc;
              if (out_free) begin
                insn       <= imem_rdata;
                pc         <= fetch_pc;
                valid_insn <= 1'b1;
                state      <= REQ;
                imem_req   <= 1'b1;
                imem_addr  <= next_pc;
`ifdef FETCH_TRACE_EN
                $display("FETCH PC: %h Insn: %h", fetch_pc, imem_rdata);
`endif
              end else begin
                hold_insn  <= imem_rdata;
                hold_pc    <= fetch_pc;
                hold_valid <= 1'b1;
                state      <= IDLE;
              end
            end
          end
          DROP: begin
            if (imem_rvalid) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
`ifdef FETCH_TRACE_EN
              $display("FETCH DROP PC: %h", imem_addr);
`endif
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed handshake sequences, a redirect vector table and a random run
// scored against an in-order program-counter model with an address-derived memory image.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [0:31] redirect_pc = '0;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [0:31] imem_rdata = '0;
  logic [0:31] insn;
  logic [0:31] pc;
  logic        valid_insn;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h8002_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .insn(insn), .pc(pc), .valid_insn(valid_insn), .fetch_misaligned(fetch_misaligned)
  );

  // memory model
  bit          rand_mode = 1'b0;
  bit          hold_gnt = 1'b0;
  int          fixed_lat = 0;
  bit          pending = 1'b0;
  int          lat_cnt = 0;
  int          gnt_cnt = 0;
  logic [31:0] paddr = '0;
  int          n_grants = 0;

  // reference model: program order of delivered words
  logic [31:0] exp_pc = RST_PC;
  int          n_delivered = 0;
  bit          exp_mis = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_req_wait = 1'b0;
  logic [31:0] prev_insn = '0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_addr = '0;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } redir_vec_t;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h2402_0005;
    if (a == 32'h8002_0008) return 32'h0000_0000;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_drive();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pending) begin
      if (lat_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memfn(paddr);
        pending     = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (imem_req && !hold_gnt) begin
      if (gnt_cnt == 0) begin
        imem_gnt = 1'b1;
        pending  = 1'b1;
        paddr    = imem_addr;
        n_grants++;
        lat_cnt  = rand_mode ? int'($urandom_range(0, 2)) : fixed_lat;
        gnt_cnt  = rand_mode ? int'($urandom_range(0, 2)) : 0;
      end else begin
        gnt_cnt--;
      end
    end
  endtask

  task automatic monitor();
    chk("misaligned_pulse", {31'b0, fetch_misaligned}, {31'b0, exp_mis});
    if (prev_hold) begin
      chk("hold_valid", {31'b0, valid_insn}, 32'd1);
      chk("hold_pc", pc, prev_pc);
      chk("hold_insn", insn, prev_insn);
    end
    if (prev_req_wait) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, prev_addr);
    end
    if (imem_req)
      chk("addr_aligned", imem_addr & 32'h3, 32'h0);
    if (valid_insn && !stall && !redirect_valid) begin
      chk("deliver_pc", pc, exp_pc);
      chk("deliver_insn", insn, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_delivered++;
    end
    if (redirect_valid)
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    exp_mis       = redirect_valid && (redirect_pc[30:31] != 2'b00);
    prev_hold     = valid_insn && stall && !redirect_valid;
    prev_req_wait = imem_req && !imem_gnt && !redirect_valid;
    prev_insn     = insn;
    prev_pc       = pc;
    prev_addr     = imem_addr;
  endtask

  // entered just after a falling edge; returns just after the next falling edge
  task automatic step();
    mem_drive();
    monitor();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 200 && !valid_insn; i++) step();
    if (!valid_insn) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_grant(input string name);
    int g;
    g = n_grants;
    for (int i = 0; i < 200 && n_grants == g; i++) step();
    if (n_grants == g) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 200 && !imem_req; i++) step();
    if (!imem_req) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_insn"}, insn, 32'h0);
    chk({name, "_pc"}, pc, 32'h0);
    chk({name, "_valid"}, {31'b0, valid_insn}, 32'd0);
    chk({name, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({name, "_addr"}, imem_addr, 32'h0);
    chk({name, "_mis"}, {31'b0, fetch_misaligned}, 32'd0);
  endtask

  initial begin
    redir_vec_t  tbl[6];
    int          g0;
    int          d0;
    logic [31:0] tgt;

    tbl[0] = '{32'h8002_0100, 32'h8002_0100, 1'b0};
    tbl[1] = '{32'h8002_0102, 32'h8002_0100, 1'b1};
    tbl[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};
    tbl[4] = '{32'h0000_0003, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h8002_0001, 32'h8002_0000, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // first fetch: gnt same cycle as req, rvalid one cycle later
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    step();
    chk("req_drop_after_gnt", {31'b0, imem_req}, 32'd0);
    step();
    chk("first_valid", {31'b0, valid_insn}, 32'd1);
    chk("first_pc", pc, 32'h8002_0000);
    chk("first_insn", insn, 32'h2402_0005);
    chk("second_addr", imem_addr, 32'h8002_0004);
    chk("second_req", {31'b0, imem_req}, 32'd1);

    // stall three cycles while the next word returns into the skid register
    step();
    step();
    chk("pre_stall_pc", pc, 32'h8002_0004);
    g0 = n_grants;
    stall = 1'b1;
    repeat (3) step();
    chk("stalled_valid", {31'b0, valid_insn}, 32'd1);
    chk("stalled_pc", pc, 32'h8002_0004);
    chk("stalled_no_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("held_word_valid", {31'b0, valid_insn}, 32'd1);
    chk("held_word_pc", pc, 32'h8002_0008);
    chk("held_word_insn", insn, 32'h0);
    chk("held_word_single_grant", n_grants - g0, 32'd1);
    chk("after_hold_addr", imem_addr, 32'h8002_000C);

    // redirect while a fetch is outstanding: via DROP, then on the rvalid edge itself
    for (int v = 0; v < 2; v++) begin
      fixed_lat = (v == 0) ? 1 : 0;
      tgt = (v == 0) ? 32'h8002_0100 : 32'h8002_0200;
      wait_grant("redir_wait_grant");
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      step();
      redirect_valid = 1'b0;
      chk("redir_valid_cleared", {31'b0, valid_insn}, 32'd0);
      if (v == 1) chk("redir_rvalid_direct_req", {31'b0, imem_req}, 32'd1);
      wait_req("redir_req");
      chk("redir_addr", imem_addr, tgt);
      wait_valid("redir_first");
      chk("redir_first_pc", pc, tgt);
    end
    fixed_lat = 0;

    // redirect vectors applied while a request waits for grant
    for (int i = 0; i < 6; i++) begin
      hold_gnt = 1'b1;
      wait_req("tbl_req");
      redirect_valid = 1'b1;
      redirect_pc    = tbl[i].rpc;
      step();
      redirect_valid = 1'b0;
      chk("tbl_req_kept", {31'b0, imem_req}, 32'd1);
      chk("tbl_addr", imem_addr, tbl[i].exp_addr);
      chk("tbl_mis", {31'b0, fetch_misaligned}, {31'b0, tbl[i].exp_mis});
      step();
      chk("tbl_mis_clear", {31'b0, fetch_misaligned}, 32'd0);
      hold_gnt = 1'b0;
      wait_valid("tbl_first");
      chk("tbl_first_pc", pc, tbl[i].exp_addr);
      step();
      wait_valid("tbl_second");
      chk("tbl_second_pc", pc, tbl[i].exp_addr + 32'd4);
    end

    // asynchronous reset while a fetch is outstanding, stray rvalid after release
    fixed_lat = 2;
    wait_grant("rst_wait_grant");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    pending = 1'b0; gnt_cnt = 0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    exp_pc = RST_PC; exp_mis = 1'b0; prev_hold = 1'b0; prev_req_wait = 1'b0;
    fixed_lat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("rst_stray_rvalid_ignored", {31'b0, valid_insn}, 32'd0);
    chk("rst_first_req", {31'b0, imem_req}, 32'd1);
    chk("rst_first_addr", imem_addr, RST_PC);
    wait_valid("rst_first");
    chk("rst_first_pc", pc, RST_PC);
    chk("rst_first_insn", insn, 32'h2402_0005);

    // random stalls, redirects and memory latencies
    rand_mode = 1'b1;
    d0 = n_delivered;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: redirect_pc = RST_PC + ($urandom_range(0, 255) << 2);
      endcase
      step();
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("random_progress", {31'b0, (n_delivered - d0) > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; the producer end of the decode stage's `insn`/`pc`/`valid_insn` interface.
- Maintains the fetch PC and issues word reads to instruction memory through a req/gnt/rvalid handshake.
- Presents each returned word with its PC to decode for one cycle, or holds it while decode stalls.
- Accepts branch/jump redirects from later stages and discards any in-flight stale fetch.

Parameters:
- RESET_PC, 32'h80020000, first fetch address after reset (word aligned).
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  decode cannot accept; hold the current output.
- redirect_valid  input  1  one-cycle pulse: change fetch PC.
- redirect_pc  input  [0:31]  new fetch address.
- imem_req  output  1  read request, held until granted.
- imem_addr  output  [0:31]  read address, stable while imem_req=1.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid, one cycle, at least 1 cycle after gnt.
- imem_rdata  input  [0:31]  instruction word.
- insn  output  [0:31]  instruction to decode.
- pc  output  [0:31]  address of `insn`.
- valid_insn  output  1  `insn`/`pc` are valid this cycle.
- fetch_misaligned  output  1  one-cycle pulse: redirect_pc had bits [30:31] != 0.

Behaviour:
- Reset (async, rst_n=0):
  - insn=0, pc=0, valid_insn=0, imem_req=0, imem_addr=0, fetch_misaligned=0.
  - fetch_pc=RESET_PC; state=IDLE.
- States: IDLE, REQ, WAIT, DROP. At most one outstanding request.
- IDLE:
  - First edge after reset release → REQ, imem_req=1, imem_addr=fetch_pc.
  - Also entered when output is held; leaves to REQ once the output is consumed (valid_insn=0, or valid_insn=1 with stall=0).
- REQ: imem_req=1 until the edge where imem_gnt=1, then → WAIT with imem_req=0.
- WAIT: on imem_rvalid:
  - If the output is free (valid_insn=0, or stall=0): insn<=imem_rdata, pc<=fetch_pc, valid_insn<=1, fetch_pc<=fetch_pc+PC_STEP, → REQ with the new address the same edge.
  - If stall=1 with valid_insn=1: the word is latched into a 1-entry holding register, → IDLE. The held word moves to the output on the first non-stall edge.
- Output handshake:
  - valid_insn with stall=0 is consumed at that edge; valid_insn drops next cycle unless a new word is delivered.
  - While stall=1 and valid_insn=1, insn/pc/valid_insn are held bit-stable.
- Redirect (priority over stall and rvalid):
  - fetch_pc<=redirect_pc with bits [30:31] forced to 0; valid_insn<=0; holding register cleared.
  - In REQ before gnt: imem_addr updates to the new PC next cycle; the request stays asserted.
  - In REQ with gnt the same cycle, or in WAIT: → DROP. The next rvalid is discarded, then → REQ at the new PC.
  - If rvalid arrives the same cycle as redirect in WAIT: data discarded, → REQ directly.
  - In IDLE: → REQ.
  - In DROP: updates fetch_pc only.
  - fetch_misaligned pulses the cycle after a misaligned redirect.
- Arithmetic: fetch_pc is 32-bit unsigned and wraps, 32'hFFFFFFFC+4 = 32'h00000000.
- Latency: redirect to first valid_insn = 2 cycles plus memory gnt/rvalid latency.
- rst_n asserted mid-transaction: all state returns to reset values immediately; a late rvalid after reset release is ignored until the first request issues.

Optional Feature:
- FETCH_TRACE_EN defined:
  - On each delivery edge, `$display("FETCH PC: %h Insn: %h", pc, insn)`.
  - On each discarded response, `$display("FETCH DROP PC: %h", pc)`.
- FETCH_TRACE_EN undefined: no display statements; cycle behaviour identical.

Test Plan:
- Reset release, memory gnt same cycle, rvalid 1 cycle later, data 32'h24020005 → first valid_insn with pc=32'h80020000, insn=32'h24020005; next request addr=32'h80020004.
- stall=1 for 3 cycles while valid_insn=1 and the next rvalid returns 32'h00000000 → output held bit-stable; after stall drops, the held word is delivered with pc=32'h80020008 and no extra memory request.
- redirect_pc=32'h80020100 during WAIT, stale rvalid arrives → stale data never appears on insn; next imem_addr=32'h80020100.
- redirect_pc=32'h80020102 → fetch_misaligned pulses 1 cycle; imem_addr=32'h80020100.
- redirect_pc=32'hFFFFFFFC, two sequential fetches → pcs 32'hFFFFFFFC then 32'h00000000.
- rst_n low while in WAIT → all outputs 0 in the same cycle; after release, first imem_addr=32'h80020000.
